// File: rtl/spi_symbol_rx_if.sv
// Bundle for the 3-cycle-symbol serial receive link: the serial side driven by the
// transmitter and the parallel byte side consumed by the hash-table logic.
interface spi_symbol_rx_if #(
  parameter int DATA_W = 8
);
  logic              in_data;
  logic              in_en;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output in_data, in_en,
    input  data_out, valid, frame_err, busy
  );

  modport slave (
    input  in_data, in_en,
    output data_out, valid, frame_err, busy
  );
endinterface

// File: rtl/spi_symbol_rx.sv
// Decodes 3-clock serial symbols (1 = H,L,L; 0 = H,H,L), LSB first, into parallel bytes
// with a one-cycle valid strobe and a one-cycle framing-error strobe.
module spi_symbol_rx #(
  parameter int DATA_W  = 8,
  parameter int MAX_GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_symbol_rx_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    S_HUNT,
    S_MID,
    S_END
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [GAP_W-1:0]  r_gapCnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_rxBit;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_valid;
  logic              r_frameErr;

  logic              w_lastBit;
  logic [DATA_W-1:0] w_shiftNext;

  assign w_lastBit = (r_bitCnt == CNT_W'(DATA_W - 1));

  // Shift register with the pending bit merged in, so completion can publish it directly.
  always_comb begin
    w_shiftNext           = r_shift;
    w_shiftNext[r_bitCnt] = r_rxBit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_HUNT;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_shift    <= '0;
      r_rxBit    <= 1'b0;
      r_dataOut  <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (!bus.in_en) begin
            r_gapCnt <= '0;
            if (r_bitCnt != '0) begin
              r_frameErr <= 1'b1;
              r_bitCnt   <= '0;
            end
          end else if (bus.in_data) begin
            r_state  <= S_MID;
            r_gapCnt <= '0;
          end else if (r_bitCnt != '0) begin
            // Idle gaps only count once a frame has started.
            if (r_gapCnt == GAP_W'(MAX_GAP - 1)) begin
              r_frameErr <= 1'b1;
              r_bitCnt   <= '0;
              r_gapCnt   <= '0;
            end else begin
              r_gapCnt <= r_gapCnt + 1'b1;
            end
          end
        end
        S_MID: begin
          r_state <= S_HUNT;
          if (!bus.in_en) begin
            r_frameErr <= 1'b1;
            r_bitCnt   <= '0;
          end else begin
            r_rxBit <= ~bus.in_data;
            r_state <= S_END;
          end
        end
        S_END: begin
          r_state <= S_HUNT;
          // The transmitter may drop enable together with the final symbol.
          if ((!bus.in_en && !w_lastBit) || bus.in_data) begin
            r_frameErr <= 1'b1;
            r_bitCnt   <= '0;
          end else begin
            r_shift <= w_shiftNext;
            if (w_lastBit) begin
              r_dataOut <= w_shiftNext;
              r_valid   <= 1'b1;
              r_bitCnt  <= '0;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  assign bus.data_out  = r_dataOut;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frameErr;
  assign bus.busy      = (r_state != S_HUNT) || (r_bitCnt != '0);

endmodule

// File: tb/tb_spi_symbol_rx.sv
// Scoreboard bench for spi_symbol_rx: directed frames push expected events, a monitor
// pops and compares whenever valid or frame_err is seen.
module tb_spi_symbol_rx;

  localparam int DATA_W  = 8;
  localparam int MAX_GAP = 4;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
  } expEvent_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  expEvent_t expQ[$];

  spi_symbol_rx_if #(.DATA_W(DATA_W)) bus ();

  spi_symbol_rx #(
    .DATA_W (DATA_W),
    .MAX_GAP(MAX_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushValid(input logic [7:0] value);
    expEvent_t e;
    e.isErr = 1'b0;
    e.data  = value;
    expQ.push_back(e);
  endtask

  task automatic pushErr();
    expEvent_t e;
    e.isErr = 1'b1;
    e.data  = 8'h00;
    expQ.push_back(e);
  endtask

  task automatic drive(input logic en, input logic d);
    bus.in_en   = en;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic sendBit(input logic b, input bit dropEnd);
    drive(1'b1, 1'b1);
    drive(1'b1, ~b);
    drive(dropEnd ? 1'b0 : 1'b1, 1'b0);
  endtask

  // Negative bit indices disable the corresponding fault injection.
  task automatic applyStimulus(input logic [7:0] value, input int gapAfterBit,
                               input int gapLen, input bit dropLast,
                               input int badBit, input int midDropBit);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == midDropBit) begin
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        return;
      end
      if (i == badBit) begin
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        return;
      end
      sendBit(value[i], dropLast && (i == DATA_W - 1));
      if (i == gapAfterBit) begin
        repeat (gapLen) drive(1'b1, 1'b0);
        if (gapLen >= MAX_GAP) return;
      end
    end
  endtask

  initial begin
    expEvent_t e;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1 || bus.frame_err === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", {30'd0, bus.valid, bus.frame_err}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_kind", {30'd0, bus.valid, bus.frame_err},
                      e.isErr ? 32'd1 : 32'd2);
          if (!e.isErr) checkOutput("event_data", {24'd0, bus.data_out}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] c3;
    c3          = 8'hC3;
    rst         = 1'b0;
    bus.in_en   = 1'b0;
    bus.in_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data_out", {24'd0, bus.data_out}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    idle(2);

    pushValid(8'hA5);
    applyStimulus(8'hA5, -1, 0, 1'b0, -1, -1);
    checkOutput("a5_valid_latency", {31'd0, bus.valid}, 32'd1);
    checkOutput("a5_busy_after", {31'd0, bus.busy}, 32'd0);
    idle(2);

    pushValid(8'h00);
    pushValid(8'hFF);
    applyStimulus(8'h00, -1, 0, 1'b0, -1, -1);
    applyStimulus(8'hFF, -1, 0, 1'b1, -1, -1);
    idle(2);

    pushErr();
    applyStimulus(8'h3C, -1, 0, 1'b0, 3, -1);
    checkOutput("bad_sample_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("bad_sample_hold", {24'd0, bus.data_out}, 32'hFF);
    idle(2);
    pushValid(8'h12);
    applyStimulus(8'h12, -1, 0, 1'b0, -1, -1);
    idle(2);

    pushErr();
    applyStimulus(8'h66, -1, 0, 1'b0, -1, 5);
    idle(3);
    checkOutput("mid_drop_hold", {24'd0, bus.data_out}, 32'h12);
    pushValid(8'h81);
    applyStimulus(8'h81, -1, 0, 1'b0, -1, -1);
    idle(2);

    pushValid(8'h5A);
    applyStimulus(8'h5A, 2, 3, 1'b0, -1, -1);
    idle(2);
    pushErr();
    applyStimulus(8'h5A, 2, 4, 1'b0, -1, -1);
    idle(3);
    checkOutput("gap_err_hold", {24'd0, bus.data_out}, 32'h5A);

    for (int i = 0; i < 4; i++) sendBit(c3[i], 1'b0);
    drive(1'b1, 1'b1);
    checkOutput("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    checkOutput("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b1;
    idle(2);
    pushValid(8'hC3);
    applyStimulus(8'hC3, -1, 0, 1'b0, -1, -1);
    idle(5);

    checkOutput("events_outstanding", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
